// File: rtl/spi_regfile_pkg.sv
// Shared definitions for the SPI register file: FSM encoding, header layout, frame length.
package spi_regfile_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Header bit positions in transmission order (bit 0 is sent first)
  localparam int HDR_RW_BIT  = 0;
  localparam int HDR_IMM_BIT = 1;

  function automatic int frame_len(input int addr_bits, input int reg_w);
    return 2 + addr_bits + reg_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// SPI pin synchronisers: 3-stage SCLK with rise/fall detect, 2-stage /SS and MOSI.
module spi_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_sclk,
  input  logic i_ss_n,
  input  logic i_mosi,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_ss_act,
  output logic o_mosi
);

  logic [2:0] r_sclk;
  logic [1:0] r_ss_n;
  logic [1:0] r_mosi;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk <= '0;
      r_ss_n <= '0;
      r_mosi <= '0;
    end else begin
      r_sclk <= {r_sclk[1:0], i_sclk};
      r_ss_n <= {r_ss_n[0], i_ss_n};
      r_mosi <= {r_mosi[0], i_mosi};
    end
  end

  // Edges compare stage 2 against stage 3 so stage 1 absorbs metastability
  assign o_sclk_rise = r_sclk[1] & ~r_sclk[2];
  assign o_sclk_fall = ~r_sclk[1] & r_sclk[2];
  assign o_ss_act    = ~r_ss_n[1];
  assign o_mosi      = r_mosi[1];

endmodule

// File: rtl/spi_regfile.sv
// SPI-slave register file with shadow buffers, pending flags and commit strobe.
// Optional MISO readback path enabled by defining SPI_REGFILE_READBACK_EN.
module spi_regfile
  import spi_regfile_pkg::*;
#(
  parameter int NUM_REGS  = 16,
  parameter int ADDR_BITS = 4,
  parameter int REG_W     = 24,
  parameter logic [NUM_REGS*REG_W-1:0] RESET_VALS = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_sclk,
  input  logic                      i_ss_n,
  input  logic                      i_mosi,
  output logic                      o_miso,
  output logic                      o_miso_oe,
  input  logic                      load_new,
  output logic [NUM_REGS*REG_W-1:0] o_regs,
  output logic [NUM_REGS-1:0]       o_pending
);

  localparam int FRAME   = frame_len(ADDR_BITS, REG_W);
  localparam int HDR_LEN = 2 + ADDR_BITS;
  localparam int CNT_W   = $clog2(FRAME + 1);
  // The rw bit is never needed once data starts, so it may fall off the top
  localparam int SH_W    = FRAME - 2;

  logic w_sclk_rise;
  logic w_ss_act;
  logic w_mosi;
`ifdef SPI_REGFILE_READBACK_EN
  logic w_sclk_fall;
`endif

  spi_sync_edge u_sync (
    .clk         (clk),
    .reset       (reset),
    .i_sclk      (i_sclk),
    .i_ss_n      (i_ss_n),
    .i_mosi      (i_mosi),
    .o_sclk_rise (w_sclk_rise),
`ifdef SPI_REGFILE_READBACK_EN
    .o_sclk_fall (w_sclk_fall),
`else
    .o_sclk_fall (),
`endif
    .o_ss_act    (w_ss_act),
    .o_mosi      (w_mosi)
  );

  logic [CNT_W-1:0]  r_cnt;
  logic [SH_W-1:0]   r_shift;
  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_hdr_last;
  logic              w_frame_last;
  logic              w_hdr_rw;
  logic              w_wr_done;

  assign w_hdr_last   = w_sclk_rise && (r_cnt == CNT_W'(HDR_LEN - 1));
  assign w_frame_last = w_sclk_rise && (r_cnt == CNT_W'(FRAME - 1));
  assign w_hdr_rw     = r_shift[HDR_LEN - 2 - HDR_RW_BIT];

  always_ff @(posedge clk) begin
    if (reset || !w_ss_act) begin
      r_cnt <= '0;
    end else if (w_sclk_rise && (r_cnt != CNT_W'(FRAME))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
    end else if (w_ss_act && w_sclk_rise && (r_cnt != CNT_W'(FRAME))) begin
      r_shift <= {r_shift[SH_W-2:0], w_mosi};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!w_ss_act) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_HDR;
        ST_HDR: begin
          if (w_hdr_last) begin
`ifdef SPI_REGFILE_READBACK_EN
            w_state_nxt = w_hdr_rw ? ST_RDATA : ST_WDATA;
`else
            w_state_nxt = w_hdr_rw ? ST_DONE : ST_WDATA;
`endif
          end
        end
        ST_WDATA: if (w_frame_last) w_state_nxt = ST_DONE;
        ST_RDATA: if (w_frame_last) w_state_nxt = ST_DONE;
        ST_DONE:  w_state_nxt = ST_DONE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_wr_done = w_ss_act && (r_state == ST_WDATA) && w_frame_last;
  end

  // Completed write is registered once, then applied on the following clk
  logic                 r_wr_done;
  logic                 r_wr_imm;
  logic [ADDR_BITS-1:0] r_wr_addr;
  logic [REG_W-1:0]     r_wr_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_done <= 1'b0;
      r_wr_imm  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_done <= w_wr_done;
      if (w_wr_done) begin
        r_wr_imm  <= r_shift[FRAME - 2 - HDR_IMM_BIT];
        r_wr_addr <= r_shift[REG_W-1 +: ADDR_BITS];
        r_wr_data <= {r_shift[REG_W-2:0], w_mosi};
      end
    end
  end

  logic [REG_W-1:0]    r_live [NUM_REGS];
  logic [REG_W-1:0]    r_buf  [NUM_REGS];
  logic [NUM_REGS-1:0] r_pend;

  // Write assignments follow the commit so an imm write overrides the commit,
  // and a non-imm write re-arms pending after the old buffer went live.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_live[i] <= RESET_VALS[i*REG_W +: REG_W];
        r_buf[i]  <= RESET_VALS[i*REG_W +: REG_W];
      end
      r_pend <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (load_new && r_pend[i]) begin
          r_live[i] <= r_buf[i];
          r_pend[i] <= 1'b0;
        end
        if (r_wr_done && (r_wr_addr == ADDR_BITS'(i))) begin
          r_buf[i]  <= r_wr_data;
          r_pend[i] <= ~r_wr_imm;
          if (r_wr_imm) r_live[i] <= r_wr_data;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign o_regs[g*REG_W +: REG_W] = r_live[g];
  end
  assign o_pending = r_pend;

`ifdef SPI_REGFILE_READBACK_EN
  logic [ADDR_BITS-1:0] w_hdr_addr;
  logic [REG_W-1:0]     w_rd_val;
  logic [REG_W-1:0]     r_rd_sh;
  logic                 w_rd_load;
  logic                 w_rd_shift;
  logic                 w_miso_oe;

  assign w_hdr_addr = ADDR_BITS'({r_shift, w_mosi});

  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_hdr_addr == ADDR_BITS'(i)) w_rd_val = r_live[i];
    end
  end

  // The fall right after the header must not shift: the MSB is sampled at the next rise
  always_comb begin
    w_rd_load  = w_ss_act && (r_state == ST_HDR) && w_hdr_last && w_hdr_rw;
    w_rd_shift = (r_state == ST_RDATA) && w_sclk_fall && (r_cnt > CNT_W'(HDR_LEN));
    w_miso_oe  = (r_state == ST_RDATA) && w_ss_act;
  end

  always_ff @(posedge clk) begin
    if (reset)           r_rd_sh <= '0;
    else if (w_rd_load)  r_rd_sh <= w_rd_val;
    else if (w_rd_shift) r_rd_sh <= {r_rd_sh[REG_W-2:0], 1'b0};
  end

  assign o_miso    = w_miso_oe & r_rd_sh[REG_W-1];
  assign o_miso_oe = w_miso_oe;
`else
  assign o_miso    = 1'b0;
  assign o_miso_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile.sv
// Directed plus randomized bench for spi_regfile against an array-based reference model.
module tb_spi_regfile;

  localparam int NR    = 12;
  localparam int AB    = 4;
  localparam int RW    = 24;
  localparam int FRAME = 2 + AB + RW;
  localparam int HDR   = 2 + AB;
`ifdef SPI_REGFILE_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  function automatic logic [NR*RW-1:0] mk_rv();
    logic [NR*RW-1:0] v;
    v = '0;
    for (int i = 0; i < NR; i++) v[i*RW +: RW] = 24'h010101 * i;
    v[3*RW +: RW] = 24'hA5A5A5;
    return v;
  endfunction
  localparam logic [NR*RW-1:0] RV = mk_rv();

  logic clk = 1'b0;
  logic reset, sclk, ss_n, mosi, load_new;
  logic miso, miso_oe;
  logic [NR*RW-1:0] regs;
  logic [NR-1:0]    pending;

  always #5 clk = ~clk;

  spi_regfile #(.NUM_REGS(NR), .ADDR_BITS(AB), .REG_W(RW), .RESET_VALS(RV)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_sclk    (sclk),
    .i_ss_n    (ss_n),
    .i_mosi    (mosi),
    .o_miso    (miso),
    .o_miso_oe (miso_oe),
    .load_new  (load_new),
    .o_regs    (regs),
    .o_pending (pending)
  );

  logic [RW-1:0] m_live [NR];
  logic [RW-1:0] m_buf  [NR];
  logic [NR-1:0] m_pend;
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NR; i++)
      chk($sformatf("%s reg%0d", tag, i), {8'h0, regs[i*RW +: RW]}, {8'h0, m_live[i]});
    chk({tag, " pending"}, {20'h0, pending}, {20'h0, m_pend});
  endtask

  task automatic model_write(input logic imm, input int addr, input logic [RW-1:0] data);
    if (addr < NR) begin
      m_buf[addr] = data;
      if (imm) begin
        m_live[addr] = data;
        m_pend[addr] = 1'b0;
      end else begin
        m_pend[addr] = 1'b1;
      end
    end
  endtask

  task automatic model_commit();
    for (int i = 0; i < NR; i++)
      if (m_pend[i]) begin
        m_live[i] = m_buf[i];
        m_pend[i] = 1'b0;
      end
  endtask

  // Mode-0 master, 8 clk per SCLK half period; optional load_new aligned to the write update cycle
  task automatic spi_frame(input logic rw, input logic imm, input logic [AB-1:0] addr,
                           input logic [RW-1:0] data, input int nbits, input bit collide,
                           output logic [RW-1:0] rd, output logic oe_seen);
    logic [FRAME-1:0] f;
    f = {rw, imm, addr, data};
    rd = '0;
    oe_seen = 1'b0;
    @(negedge clk) ss_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      mosi = f[FRAME-1-b];
      repeat (8) @(negedge clk);
      if (b >= HDR) begin
        rd = {rd[RW-2:0], miso};
        if (b == HDR + 2) oe_seen = miso_oe;
      end
      sclk = 1'b1;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (collide && b == FRAME - 1) begin
          if (k == 2) load_new = 1'b1;
          else if (k == 3) load_new = 1'b0;
        end
      end
      sclk = 1'b0;
    end
    repeat (6) @(negedge clk);
    ss_n = 1'b1;
    mosi = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_write(input logic imm, input int addr, input logic [RW-1:0] data, input bit collide);
    logic [RW-1:0] rd;
    logic oe;
    spi_frame(1'b0, imm, AB'(addr), data, FRAME, collide, rd, oe);
    if (collide) model_commit();
    model_write(imm, addr, data);
  endtask

  task automatic do_commit();
    @(negedge clk) load_new = 1'b1;
    @(negedge clk) load_new = 1'b0;
    model_commit();
    @(negedge clk);
  endtask

  task automatic do_read(input string tag, input int addr);
    logic [RW-1:0] rd, exp;
    logic oe;
    spi_frame(1'b1, 1'b0, AB'(addr), '0, FRAME, 1'b0, rd, oe);
    exp = (RB && addr < NR) ? m_live[addr] : '0;
    chk({tag, " miso data"}, {8'h0, rd}, {8'h0, exp});
    chk({tag, " miso_oe"}, {31'h0, oe}, {31'h0, RB});
  endtask

  initial begin
    logic [RW-1:0] rd;
    logic oe;
    reset = 1'b1; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0; load_new = 1'b0;
    for (int i = 0; i < NR; i++) begin
      m_live[i] = RV[i*RW +: RW];
      m_buf[i]  = RV[i*RW +: RW];
    end
    m_pend = '0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_all("reset");
    chk("reset reg3", {8'h0, regs[3*RW +: RW]}, 32'h00A5A5A5);
    chk("reset miso_oe", {31'h0, miso_oe}, 32'h0);
    chk("reset miso", {31'h0, miso}, 32'h0);

    do_write(1'b0, 2, 24'h123456, 1'b0);
    check_all("buffered");
    chk("buffered pend2", {31'h0, pending[2]}, 32'h1);
    do_commit();
    check_all("commit");
    chk("commit reg2", {8'h0, regs[2*RW +: RW]}, 32'h00123456);

    do_write(1'b1, 5, 24'hFFFFFF, 1'b0);
    check_all("imm");
    chk("imm reg5", {8'h0, regs[5*RW +: RW]}, 32'h00FFFFFF);

    do_write(1'b0, 1, 24'h000011, 1'b0);
    do_write(1'b0, 1, 24'h000022, 1'b1);
    check_all("collide");
    chk("collide reg1", {8'h0, regs[1*RW +: RW]}, 32'h00000011);
    chk("collide pend1", {31'h0, pending[1]}, 32'h1);
    do_commit();
    chk("collide commit reg1", {8'h0, regs[1*RW +: RW]}, 32'h00000022);

    spi_frame(1'b0, 1'b1, 4'd4, 24'hABCDEF, HDR + 10, 1'b0, rd, oe);
    check_all("short");
    do_write(1'b1, 15, 24'h5A5A5A, 1'b0);
    do_write(1'b0, 12, 24'h777777, 1'b0);
    check_all("range");

    do_read("read2", 2);
    do_read("read15", 15);
    do_read("read3", 3);
    check_all("after reads");

    for (int n = 0; n < 30; n++) begin
      int op, a, nb;
      logic [RW-1:0] d;
      op = $urandom_range(0, 5);
      a  = $urandom_range(0, 15);
      d  = RW'($urandom);
      case (op)
        0, 1: do_write(1'($urandom_range(0, 1)), a, d, 1'b0);
        2:    do_write(1'($urandom_range(0, 1)), a, d, 1'b1);
        3:    do_commit();
        4:    do_read($sformatf("rnd%0d read%0d", n, a), a);
        default: begin
          nb = $urandom_range(1, FRAME - 1);
          spi_frame(1'b0, 1'($urandom_range(0, 1)), AB'(a), d, nb, 1'b0, rd, oe);
        end
      endcase
      check_all($sformatf("rnd%0d op%0d", n, op));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_regfile.md
# spi_regfile

Parametrised SPI-slave register file for the raybox-zero host-control path. It holds NUM_REGS registers of REG_W bits each. Every register is written over SPI into a shadow buffer, and each written register is marked pending. Pending registers go live together when `load_new` pulses, or immediately if the frame requests it. An optional MISO readback path returns live register values. The block sits between the external SPI pins and the rendering core, with `load_new` driven by the frame timing (VBLANK).

## Interface
Parameters:
- `NUM_REGS`, 16: number of registers. Range 1..2^ADDR_BITS.
- `ADDR_BITS`, 4: width of the address field in the frame header.
- `REG_W`, 24: width of every register.
- `RESET_VALS`, all zeros: flattened NUM_REGS*REG_W reset image. Register i occupies bits [i*REG_W +: REG_W].

Ports:
- `clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high; clock clk.
- `i_sclk`, `i_ss_n`, `i_mosi` in 1 each: raw asynchronous SPI pins (mode 0).
- `o_miso` out 1: readback data.
- `o_miso_oe` out 1: high while `/SS` is synchronised-active and a read frame is in its data phase.
- `load_new` in 1: commit strobe.
- `o_regs` out NUM_REGS*REG_W: live register values. Layout matches `RESET_VALS`.
- `o_pending` out NUM_REGS: one bit per register; set while that register's shadow buffer holds an uncommitted write.

## Operation
- **Input synchronisers:**
  - `sclk`: 3-stage synchroniser; rise and fall are both detected from stages 2/3.
  - `ss_n` and `mosi`: 2 stages each.
- **Frame format (MSB first):**
  - `rw` bit: 1 = read.
  - `imm` bit.
  - ADDR_BITS address bits.
  - REG_W data bits.
  - Frame length is therefore FRAME = 2 + ADDR_BITS + REG_W.
- **Bit counter:**
  - Counts synchronised SCLK rises while `/SS` is active.
  - Stalls at FRAME; any further bits are ignored.
  - Cleared whenever `/SS` is inactive.
- **FSM states:**
  - IDLE: `/SS` inactive. Moves to HDR on `/SS` active.
  - HDR: header shift. After header bit 2+ADDR_BITS, moves to WDATA or RDATA.
  - WDATA: data shift for a write. On the FRAME-th rise, moves to DONE.
  - RDATA: data shift for a read. On the FRAME-th rise, moves to DONE.
  - DONE: stalls until `/SS` goes inactive, then returns to IDLE.
  - Deassertion of `/SS` in any state returns the FSM to IDLE.
- **Write completion:** on the FRAME-th rise in WDATA, a one-cycle `wr_done` is raised. On the next clk:
  - If addr < NUM_REGS and `imm`=0: buffer[addr] ← data and pending[addr] ← 1.
  - If addr < NUM_REGS and `imm`=1: live[addr] and buffer[addr] ← data, and pending[addr] ← 0.
  - If addr ≥ NUM_REGS: no effect.
- **Short frames:** `/SS` deasserted before FRAME bits are received causes no state change.
- **Commit:** when `load_new`=1, every register with pending=1 copies buffer to live and its pending bit clears. Registers that are not pending are untouched.
- **Simultaneous `load_new` and write to the same register:**
  - Non-imm write: the commit uses the old buffer. The new value lands in the buffer and pending stays 1.
  - Imm write: the imm data wins.
- **Reads:**
  - The live value is latched at the end of the header (last header rise).
  - The MSB drives `o_miso` immediately.
  - Subsequent bits shift on synchronised SCLK falls.
  - addr ≥ NUM_REGS reads 0.
  - Reads never alter state.
- **Reset:**
  - live = buffer = `RESET_VALS`.
  - pending = 0.
  - FSM = IDLE, counter = 0.
  - `o_miso` = 0, `o_miso_oe` = 0.
  - Synchroniser stages = 0.
  - Reset mid-frame discards the frame.

## Timing
- Pin-to-detect latency is 3 clk for SCLK edges and 2 clk for `/SS` and MOSI.
- SCLK high and low periods must each be ≥ 4 clk. The MOSI setup window follows from this.
- Write: `wr_done` fires 3 clk after the final SCLK pin rise. Buffer, pending, or live (imm) update 1 clk later.
- Commit: `o_regs` updates in the clk after the `load_new` cycle.
- Read:
  - `o_miso` changes ≤ 4 clk after the SCLK pin fall.
  - First data bit is valid ≤ 4 clk after the last header rise. This meets mode-0 sampling at the next master rise.
- `/SS` inactive forces `o_miso_oe`=0 within 2 clk.

## Configuration
- `SPI_REGFILE_READBACK_EN` defined:
  - RDATA state, read shifter and MISO logic are present.
- `SPI_REGFILE_READBACK_EN` undefined:
  - `o_miso` and `o_miso_oe` are tied 0.
  - A frame with `rw`=1 moves the FSM from HDR straight to DONE. It is ignored, with no state change.
  - Writes are unaffected.

## Structure
- Shared package `spi_regfile_pkg`:
  - FSM state encoding (IDLE/HDR/WDATA/RDATA/DONE).
  - Header bit positions (`rw`, `imm`).
  - Frame-length function of ADDR_BITS and REG_W.
- Sub-module `spi_sync_edge`: the SCLK/SS/MOSI synchronisers plus rise/fall detectors. It is reusable by other SPI-facing blocks.
- Top level holds the FSM, counter, shifters, buffer, live and pending arrays.

## Test plan
- **Reset:**
  - Stimulus: apply reset.
  - Required: `o_regs` equals `RESET_VALS` (use non-zero 0xA5A5A5 for reg 3); `o_pending`=0; `o_miso_oe`=0.
- **Buffered write:**
  - Stimulus: write reg 2 = 0x123456 with `imm`=0.
  - Required: `o_pending[2]`=1 and live reg 2 unchanged. After `load_new`, live = 0x123456 and pending = 0.
- **Immediate write:**
  - Stimulus: write reg 5 = 0xFFFFFF with `imm`=1.
  - Required: live reg 5 updates without `load_new`; pending[5]=0.
- **Collision:**
  - Stimulus: pending reg 1 = 0x000011; a new non-imm write of 0x000022 completes in the same cycle as `load_new`.
  - Required: live = 0x000011 and pending[1]=1. The next `load_new` makes live = 0x000022.
- **Short frame and out-of-range address:**
  - Stimulus: frame aborted after 10 data bits; a write to address 15 with NUM_REGS=12.
  - Required: no register changes.
- **Readback (`SPI_REGFILE_READBACK_EN` defined):**
  - Stimulus: read reg 2 after the commit above.
  - Required: MISO returns 0x123456 MSB-first. Reading address 15 returns 0. With the macro undefined, MISO stays 0.
